// File: rtl/step_enable_gen.sv
// Push-button front end for the single-cycle CPU: synchronise, debounce, and
// turn presses into clk_en pulses in step, free-run or fixed-length burst mode.
module step_enable_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DIV_W           = 24,
  parameter int BURST_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clk_en,
  output logic               btn_clean,
  output logic               busy
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_STEP  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]         sync_q;
  logic               btn_sync;
  logic [DB_W-1:0]    db_cnt;
  logic               btn_clean_d;
  logic               press;

  logic [DIV_W-1:0]   div_q, div_q_next;
  logic [DIV_W-1:0]   rate_q, rate_next;
  logic [BURST_W-1:0] remain_q, remain_next;
  logic               clk_en_next;
  logic               busy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  assign btn_sync = sync_q[1];

  // btn_clean only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      btn_clean_d <= 1'b0;
    end else begin
      btn_clean_d <= btn_clean;
      if (btn_sync == btn_clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_clean <= btn_sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign press = btn_clean & ~btn_clean_d;

  always_comb begin
    state_next  = state;
    clk_en_next = 1'b0;
    div_q_next  = div_q;
    rate_next   = rate_q;
    remain_next = remain_q;

    case (state)
      IDLE: begin
        rate_next   = '0;
        remain_next = '0;
        if (press) begin
          case (mode)
            MODE_STEP: clk_en_next = 1'b1;
            MODE_RUN: begin
              div_q_next  = div;
              clk_en_next = 1'b1;
              state_next  = RUN;
            end
            MODE_BURST: begin
              if (burst_len != '0) begin
                div_q_next  = div;
                remain_next = burst_len - BURST_W'(1);
                clk_en_next = 1'b1;
                state_next  = BURST;
              end
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        if ((mode != MODE_RUN) || press) begin
          state_next = IDLE;
          rate_next  = '0;
        end else if (rate_q == div_q) begin
          rate_next   = '0;
          clk_en_next = 1'b1;
        end else begin
          rate_next = rate_q + DIV_W'(1);
        end
      end

      BURST: begin
        // remain_q reaches zero only once the final pulse has been registered.
        if ((mode != MODE_BURST) || (remain_q == '0)) begin
          state_next  = IDLE;
          rate_next   = '0;
          remain_next = '0;
        end else if (rate_q == div_q) begin
          rate_next   = '0;
          clk_en_next = 1'b1;
          remain_next = remain_q - BURST_W'(1);
        end else begin
          rate_next = rate_q + DIV_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        rate_next  = '0;
      end
    endcase

    busy_next = (state_next == RUN) || (state_next == BURST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clk_en   <= 1'b0;
      busy     <= 1'b0;
      div_q    <= '0;
      rate_q   <= '0;
      remain_q <= '0;
    end else begin
      state    <= state_next;
      clk_en   <= clk_en_next;
      busy     <= busy_next;
      div_q    <= div_q_next;
      rate_q   <= rate_next;
      remain_q <= remain_next;
    end
  end

endmodule

// File: tb/tb_step_enable_gen.sv
// Directed bench for step_enable_gen: pulse cycles are logged and compared
// against hand-computed expected cycle numbers.
module tb_step_enable_gen;

  localparam int DB      = 4;
  localparam int DIV_W   = 8;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               btn;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst_len;
  logic               clk_en;
  logic               btn_clean;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_seen = 0;
  int rate_max = 0;
  int p;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  step_enable_gen #(
    .DEBOUNCE_CYCLES(DB),
    .DIV_W(DIV_W),
    .BURST_W(BURST_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .mode(mode),
    .div(div),
    .burst_len(burst_len),
    .clk_en(clk_en),
    .btn_clean(btn_clean),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling 1ns after each rising edge.
  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (clk_en === 1'b1) got_q.push_back(32'(cyc));
      if (busy === 1'b1) busy_seen = 1;
      if (int'(dut.rate_q) > rate_max) rate_max = int'(dut.rate_q);
    end
  endtask

  // Button high for 4 samples: btn_clean rises 6 edges in, falls 10 edges in.
  task automatic short_press();
    btn = 1'b1;
    record(4);
    btn = 1'b0;
    record(6);
  endtask

  task automatic expect_series(input int start, input int step, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(32'(start + i * step));
  endtask

  task automatic compare_pulses(input string tag);
    int n;
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pulse%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; btn = 1'b0; mode = 2'b00; div = '0; burst_len = '0;
    record(3);
    check("rst_clk_en", 32'(clk_en), 0);
    check("rst_btn_clean", 32'(btn_clean), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rate", 32'(dut.rate_q), 0);
    reset = 1'b0;
    got_q.delete();
    busy_seen = 0;

    // 1: step mode with a bouncing button, then held high.
    for (int i = 0; i < 12; i++) begin
      btn = ((i / 2) % 2 == 0);
      record(1);
    end
    btn = 1'b1;
    p = cyc + 7;
    record(5);
    check("t1_clean_pre", 32'(btn_clean), 0);
    record(1);
    check("t1_clean_rise", 32'(btn_clean), 1);
    record(1);
    check("t1_first_pulse", 32'(clk_en), 1);
    record(23);
    btn = 1'b0;
    record(8);
    expect_series(p, 1, 1);
    compare_pulses("t1");
    check("t1_busy_never", 32'(busy_seen), 0);

    // 2: run mode, div=3, div changed mid-run, stopped by a second press.
    mode = 2'b01; div = 8'd3;
    p = cyc + 7;
    btn = 1'b1;
    record(7);
    check("t2_busy_on", 32'(busy), 1);
    btn = 1'b0;
    record(5);
    div = 8'd0;
    record(10);
    btn = 1'b1;
    record(6);
    check("t2_busy_before_stop", 32'(busy), 1);
    record(1);
    check("t2_busy_after_stop", 32'(busy), 0);
    btn = 1'b0;
    record(10);
    expect_series(p, 4, 6);
    compare_pulses("t2");

    // 3a: burst of 5 at div=1.
    mode = 2'b10; div = 8'd1; burst_len = 8'd5;
    p = cyc + 7;
    short_press();
    record(5);
    check("t3_busy_last", 32'(busy), 1);
    record(1);
    check("t3_busy_fall", 32'(busy), 0);
    record(4);
    expect_series(p, 2, 5);
    compare_pulses("t3a");

    // 3b: zero-length burst never starts.
    burst_len = 8'd0;
    busy_seen = 0;
    short_press();
    record(10);
    compare_pulses("t3b");
    check("t3b_busy_never", 32'(busy_seen), 0);

    // 3c: burst of 5 at div=3; inputs change and a press lands mid-burst.
    burst_len = 8'd5; div = 8'd3;
    p = cyc + 7;
    short_press();
    burst_len = 8'd9; div = 8'd0;
    short_press();
    record(10);
    expect_series(p, 4, 5);
    compare_pulses("t3c");

    // 4: long burst aborted by a switch to hold mode after 10 pulses.
    mode = 2'b10; div = 8'd0; burst_len = 8'd200;
    p = cyc + 7;
    short_press();
    record(6);
    mode = 2'b11;
    record(1);
    check("t4_abort_clk_en", 32'(clk_en), 0);
    check("t4_abort_busy", 32'(busy), 0);
    busy_seen = 0;
    record(5);
    short_press();
    record(10);
    expect_series(p, 1, 10);
    compare_pulses("t4");
    check("t4_hold_busy", 32'(busy_seen), 0);

    // 5: reset during run with btn held; re-debounce restarts run.
    mode = 2'b01; div = 8'd2;
    p = cyc + 7;
    btn = 1'b1;
    record(12);
    reset = 1'b1;
    record(1);
    check("t5_rst_clk_en", 32'(clk_en), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_btn_clean", 32'(btn_clean), 0);
    reset = 1'b0;
    record(5);
    check("t5_clean_pre", 32'(btn_clean), 0);
    record(1);
    check("t5_clean_rise", 32'(btn_clean), 1);
    record(8);
    check("t5_busy_rerun", 32'(busy), 1);
    btn = 1'b0;
    record(6);
    short_press();
    record(4);
    check("t5_busy_end", 32'(busy), 0);
    exp_q.push_back(32'(p));
    exp_q.push_back(32'(p + 3));
    expect_series(p + 13, 3, 7);
    compare_pulses("t5");

    // 6: run with div=0 gives a continuous enable; rate counter stays 0.
    mode = 2'b01; div = 8'd0;
    rate_max = 0;
    p = cyc + 7;
    short_press();
    record(20);
    short_press();
    record(5);
    check("t6_busy_end", 32'(busy), 0);
    check("t6_rate_max", 32'(rate_max), 0);
    expect_series(p, 1, 30);
    compare_pulses("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_enable_gen.md
Name: step_enable_gen

Overview:
- Parametrised successor to the single-cycle button clock-enable FSM.
- Turns a raw, bouncing push-button into clock-enable pulses for the single-cycle CPU.
- Adds synchronisation and debounce on the button.
- Adds three modes: single-step, free-run at a programmable rate, and fixed-length burst.
- Sits between the board button and the CPU's clock-enable input.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before btn_clean changes; legal range ≥1.
DIV_W, 24, width of div input and internal rate counter.
BURST_W, 8, width of burst_len input and internal burst counter.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn  input  1  raw asynchronous push-button
mode  input  2  00 step, 01 run, 10 burst, 11 hold
div  input  DIV_W  run/burst spacing; one pulse every div+1 cycles
burst_len  input  BURST_W  pulses per burst
clk_en  output  1  registered one-cycle enable pulses to the CPU
btn_clean  output  1  debounced button level
busy  output  1  high while in RUN or BURST

Behaviour:
- Reset (synchronous, sampled on posedge clk):
  - clk_en, btn_clean and busy are 0.
  - Synchroniser flops, debounce counter, rate counter and burst counter are 0.
  - FSM goes to IDLE.
- Synchroniser: two flops on btn, giving btn_sync.
- Debounce:
  - Counter increments each cycle btn_sync != btn_clean, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, btn_clean <= btn_sync and the counter clears.
  - Result: btn_clean follows a stable btn level 2+DEBOUNCE_CYCLES edges after btn first samples high.
  - press = one-cycle internal strobe on the btn_clean 0->1 transition. Release produces no event.
- Pulse timing: the first clk_en pulse of any operation is high in the cycle after press; it is registered, so it rises one edge after btn_clean rises.
- FSM states: IDLE, RUN, BURST.
- IDLE:
  - mode 00 and press: clk_en=1 for exactly one cycle; stay IDLE. Holding btn produces no further pulses.
  - mode 01 and press: latch div into div_q, emit the first pulse, go to RUN.
  - mode 10 and press with burst_len != 0: latch div_q and burst_len, emit the first pulse, go to BURST.
  - mode 10 and press with burst_len == 0: no pulse; stay IDLE.
  - mode 11: press ignored.
- RUN:
  - Rate counter counts 0..div_q and wraps to 0.
  - clk_en=1 on each wrap, so pulses are exactly div_q+1 cycles apart; div_q=0 gives clk_en high every cycle.
  - press: go to IDLE. No pulse is issued in that cycle or after.
- BURST:
  - Same spacing rule as RUN.
  - Remaining count decrements on each pulse.
  - After the burst_len-th pulse, go to IDLE; busy falls in the cycle after the last pulse.
  - press is ignored.
- Input sampling: div and burst_len changes after the start press have no effect until the next start.
- mode change while in RUN or BURST:
  - Abort to IDLE on the next edge.
  - clk_en is 0 from that edge onward; counters clear.
  - A pulse already registered in the current cycle still completes.
- busy = (state == RUN) || (state == BURST), registered with the state.
- A press coincident with a mode change is evaluated against the new mode only after the abort, so it is dropped.
- Reset mid-operation: all outputs 0 on the next edge.
  - If btn is held high across reset release, btn_clean re-debounces high and one press is generated; this is required behaviour.
- Counter widths:
  - Rate counter compares equal to div_q, so there is no overflow.
  - Burst counter never underflows; a zero length never enters BURST.

Test Plan:
1. DEBOUNCE_CYCLES=4, mode=00, btn bounces (toggle every 2 cycles for 12 cycles) then held high 30 cycles -> exactly one clk_en pulse; btn_clean rises 6 edges after btn stabilises; clk_en high on the following cycle; busy stays 0.
2. mode=01, div=3, press -> clk_en high on cycles P, P+4, P+8, ...; busy=1; div changed to 0 mid-run keeps 4-cycle spacing; second press -> no further pulses, busy=0 next edge.
3. mode=10, burst_len=5, div=1, press -> exactly 5 pulses at P, P+2, ..., P+8; busy falls at P+9; a press at P+3 is ignored; repeat with burst_len=0 -> no pulses, busy stays 0.
4. mode=10, burst_len=200, div=0, switch mode to 11 after 10 pulses -> clk_en 0 from the next edge, busy 0, later presses in mode 11 give no pulses.
5. mode=01 running, assert reset 1 cycle with btn held high -> clk_en, busy, btn_clean 0 on next edge; after release, exactly one press is detected 2+DEBOUNCE_CYCLES edges later and RUN restarts.
6. mode=01, div=0, press -> clk_en continuously high until the stop press; rate counter never exceeds 0.
